ysyx_22040729_lsu: RTL and testbench
====================================

// Module: ysyx_22040729_lsu
// PURPOSE
//  Load/store unit sitting directly upstream of the data port of the byte-addressed core memory.
//  Accepts one load/store request at a time from execute and drives the memory's addr/wen/wdata.
//  Absorbs the memory's 1-cycle registered read latency and sign/zero-extends load data.
//  The memory always writes 8 bytes, so B/H/W stores use read-modify-write; D stores write directly.
// PARAMETERS
//  DATA_DEPTH  1024  memory size in bytes; AW = $clog2(DATA_DEPTH)
//  DATA_WIDTH  64    memory data width; only 64 is supported
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request valid
//  req_ready   out  1   request accepted when valid&ready at posedge
//  req_wen     in   1   1=store, 0=load
//  req_size    in   2   0=B,1=H,2=W,3=D
//  req_unsign  in   1   load zero-extend (LBU/LHU/LWU); ignored for D and stores
//  req_addr    in   AW  byte address
//  req_wdata   in   64  store data, low 2^size bytes used
//  resp_valid  out  1   response valid
//  resp_ready  in   1   response consumed when valid&ready at posedge
//  resp_rdata  out  64  extended load data; 0 for stores
//  mem_wen     out  1   to memory wen
//  mem_addr    out  AW  to memory addr
//  mem_wdata   out  64  to memory wdata
//  mem_rdata   in   64  from memory rdata (= 8 bytes at addr presented on the previous edge)
// BEHAVIOUR
//  Reset: state=IDLE, resp_valid=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0, latched regs=0.
//  req_ready = (state==IDLE). Handshake latches wen/size/unsign/addr/wdata.
//  mem_addr is always the latched addr; mem_wen = (state==WR) only, combinational from state.
//  FSM:
//   IDLE -> WR on accepted D store (mem_wdata=req_wdata); -> RD on any other accepted request.
//   RD: mem_wen=0, address presented; -> CAP.
//   CAP: mem_rdata valid. Load: resp_rdata <= extend(mem_rdata[8*2^size-1:0]) -> RESP.
//        Store: wbuf <= mem_rdata with low 2^size bytes replaced by wdata -> WR.
//   WR: mem_wen=1, mem_wdata=wbuf; resp_rdata <= 0 -> RESP.
//   RESP: resp_valid=1; resp_rdata and all mem outputs held stable; -> IDLE on resp_ready.
//  Extension: signed loads replicate bit 8*2^size-1 to bit 63; unsigned zero-fill.
//  Latency (accept edge=cycle 0): D store resp_valid cycle 2; load cycle 3; B/H/W store cycle 4.
//  RMW preserves memory bytes addr+2^size .. addr+7 exactly.
//  Alignment: unaligned addresses are accepted unchanged; addr+i wraps modulo DATA_DEPTH in memory.
//  Back-to-back: next request is accepted no earlier than the cycle after the resp handshake.
//  Backpressure: RESP may stall indefinitely; no memory write occurs while stalled.
//  req inputs are ignored outside IDLE.
//  Async rst mid-operation: returns to IDLE immediately and drops mem_wen the same instant.
//   The pending request is dropped and no response is produced.
//   If rst asserts before the WR edge, memory is unmodified.
// TESTING
//  T1 SD 0x1122334455667788 @0x10; LD @0x10 -> resp_valid at cycles 2 and 3; LD data 0x1122334455667788.
//  T2 After T1, SB 0xAB @0x13; LD @0x10 -> 0x11223344AB667788; bytes 0x18..0x1A unchanged; mem_wen high exactly 1 cycle.
//  T3 After T2: LB @0x13 -> 0xFFFFFFFFFFFFFFAB; LBU -> 0xAB; LH @0x12 -> 0xFFFFFFFFFFFFAB66;
//     LW @0x10 -> 0xFFFFFFFFAB667788; LWU -> 0x00000000AB667788.
//  T4 Hold resp_ready=0 for 5 cycles on a load: resp_valid=1 and data stable throughout.
//     req_ready=0 and mem_wen=0 throughout; the load completes on the first resp_ready.
//  T5 Assert rst during CAP of SH 0xBEEF @0x20 -> mem_wen never 1 and LD @0x20 returns the prior value.
//     resp_valid=0 and req_ready=1 after rst release.
//  T6 req_valid held high across two LDs -> second accepted the cycle after the first resp handshake.
//     Both responses are correct and in order.

Source files
------------

// File: rtl/ysyx_22040729_lsu.sv
// Load/store unit in front of the core data memory.
// One request in flight at a time. Loads wait out the memory's registered read
// and extend the result. Sub-doubleword stores read-modify-write the 8-byte word,
// because the memory always writes all 8 bytes at once.
module ysyx_22040729_lsu #(
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 64,
    localparam int AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsign,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_wen,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;

    state_t                r_state, w_next;
    logic                  r_wen, r_unsign;
    logic [1:0]            r_size;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_mem_wdata, r_rdata;
    logic [DATA_WIDTH-1:0] w_ext, w_merge;
    logic [7:0]            w_bmask;
    logic                  w_accept;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign w_accept   = req_valid && req_ready;
    // Write enable is decoded straight from state so an async reset drops it at once.
    assign mem_wen    = (r_state == S_WR);
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: D stores skip the read; everything else reads first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = (req_wen && req_size == 2'd3) ? S_WR : S_RD;
            S_RD:   w_next = S_CAP;
            S_CAP:  w_next = r_wen ? S_WR : S_RESP;
            S_WR:   w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Load extension of the low 2^size bytes of the captured word.
    always_comb begin
        w_ext = mem_rdata;
        case (r_size)
            2'd0: w_ext = r_unsign ? {56'b0, mem_rdata[7:0]}  : {{56{mem_rdata[7]}},  mem_rdata[7:0]};
            2'd1: w_ext = r_unsign ? {48'b0, mem_rdata[15:0]} : {{48{mem_rdata[15]}}, mem_rdata[15:0]};
            2'd2: w_ext = r_unsign ? {32'b0, mem_rdata[31:0]} : {{32{mem_rdata[31]}}, mem_rdata[31:0]};
            default: w_ext = mem_rdata;
        endcase
    end

    // Merge store bytes over the old word; bytes above 2^size keep memory contents.
    always_comb begin
        case (r_size)
            2'd0:    w_bmask = 8'h01;
            2'd1:    w_bmask = 8'h03;
            2'd2:    w_bmask = 8'h0F;
            default: w_bmask = 8'hFF;
        endcase
        w_merge = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (w_bmask[i]) w_merge[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    // Request latch, write buffer and response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen       <= 1'b0;
            r_unsign    <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wen    <= req_wen;
                        r_unsign <= req_unsign;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (req_wen && req_size == 2'd3) r_mem_wdata <= req_wdata;
                    end
                end
                S_CAP: begin
                    if (r_wen) r_mem_wdata <= w_merge;
                    else       r_rdata     <= w_ext;
                end
                S_WR:    r_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040729_lsu.sv
// Bench for the LSU: byte-addressed memory model with registered read,
// scoreboard queue of expected responses checked by a separate monitor.
module tb_ysyx_22040729_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata = '0;

    typedef struct {
        logic [63:0] data;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, hs_cyc = 0, wen_cnt = 0;
    bit seen_valid = 1'b1;
    logic [7:0] mem [0:1023];

    ysyx_22040729_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;

    // Memory model: 8-byte write on wen, registered 8-byte read, addresses wrap.
    always @(posedge clk) begin
        logic [63:0] rd;
        logic [9:0]  a;
        for (int i = 0; i < 8; i++) begin
            a = mem_addr + 10'(i);
            rd[8*i +: 8] = mem[a];
            if (mem_wen) mem[a] <= mem_wdata[8*i +: 8];
        end
        mem_rdata <= rd;
        if (mem_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: latency on first resp_valid, data on every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b1;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc    = cyc;
                seen_valid = 1'b0;
            end
            if (resp_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (exp_q.size() > 0) check("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
                else fail_now("unexpected_resp");
            end
            if (resp_valid && resp_ready) begin
                hs_cyc = cyc;
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_data", resp_rdata, e.data);
                end else fail_now("unexpected_resp");
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int g = 0;
        do begin @(negedge clk); g++; end while (!req_ready && g < 20);
        ok = req_ready;
    endtask

    task automatic wait_resp(output bit ok);
        int g = 0;
        do begin @(negedge clk); g++; end while (!resp_valid && g < 20);
        ok = resp_valid;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_wen   = 1'b1;
        req_addr  = 10'h3FF;
        req_wdata = '1;
    endtask

    // One complete transaction; stall>0 holds resp_ready low and checks stability.
    task automatic txn(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp, input int lat, input int stall);
        bit ok;
        exp_q.push_back('{data: exp, lat: lat});
        resp_ready = (stall == 0);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsign = uns;
        req_addr = addr; req_wdata = wdata;
        wait_ready(ok);
        if (!ok) begin
            fail_now("accept");
            drop_req();
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        drop_req();
        wait_resp(ok);
        if (!ok) begin
            fail_now("resp");
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            resp_ready = 1'b1;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_data", resp_rdata, exp);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_wen", 64'(mem_wen), 64'd0);
            check("stall_addr", 64'(mem_addr), 64'(addr));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        if (stall > 0) begin @(posedge clk); #1; end
    endtask

    initial begin
        int  w0;
        bit  ok;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: SD then LD
        w0 = wen_cnt;
        txn(1, 3, 0, 10'h010, 64'h1122334455667788, 64'd0, 2, 0);
        check("sd_wen_cycles", 64'(wen_cnt - w0), 64'd1);
        txn(0, 3, 0, 10'h010, 64'd0, 64'h1122334455667788, 3, 0);

        // T2: SB with junk upper wdata, then LD
        w0 = wen_cnt;
        txn(1, 0, 0, 10'h013, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 4, 0);
        check("sb_wen_cycles", 64'(wen_cnt - w0), 64'd1);
        txn(0, 3, 0, 10'h010, 64'd0, 64'h11223344AB667788, 3, 0);
        check("mem_18", 64'(mem[10'h018]), 64'h42);
        check("mem_19", 64'(mem[10'h019]), 64'h43);
        check("mem_1a", 64'(mem[10'h01A]), 64'h40);

        // T3: extension
        txn(0, 0, 0, 10'h013, 64'd0, 64'hFFFFFFFFFFFFFFAB, 3, 0);
        txn(0, 0, 1, 10'h013, 64'd0, 64'h00000000000000AB, 3, 0);
        txn(0, 1, 0, 10'h012, 64'd0, 64'hFFFFFFFFFFFFAB66, 3, 0);
        txn(0, 2, 0, 10'h010, 64'd0, 64'hFFFFFFFFAB667788, 3, 0);
        txn(0, 2, 1, 10'h010, 64'd0, 64'h00000000AB667788, 3, 0);

        // Unaligned SW preserving neighbours, and wrap-around reads
        txn(1, 2, 0, 10'h031, 64'hFFFFFFFF_DEADBEEF, 64'd0, 4, 0);
        txn(0, 3, 0, 10'h030, 64'd0, 64'h6D6C6FDEADBEEF6A, 3, 0);
        txn(0, 3, 0, 10'h3FC, 64'd0, 64'h59585B5AA5A4A7A6, 3, 0);
        txn(0, 1, 1, 10'h3FF, 64'd0, 64'h0000000000005AA5, 3, 0);

        // T4: backpressure
        txn(0, 3, 0, 10'h010, 64'd0, 64'h11223344AB667788, 3, 5);

        // T5: reset during CAP of SH
        w0 = wen_cnt;
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd1; req_unsign = 1'b0;
        req_addr = 10'h020; req_wdata = 64'hBEEF;
        wait_ready(ok);
        if (!ok) fail_now("sh_accept");
        @(posedge clk); #1;
        drop_req();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_drop_wen", 64'(mem_wen), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("rst_no_write", 64'(wen_cnt - w0), 64'd0);
        txn(0, 3, 0, 10'h020, 64'd0, 64'h7D7C7F7E79787B7A, 3, 0);

        // T6: req_valid held across two loads
        exp_q.push_back('{data: 64'h11223344AB667788, lat: 3});
        exp_q.push_back('{data: 64'hFFFFFFFFFFFFFFAB, lat: 3});
        resp_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsign = 1'b0;
        req_addr = 10'h010; req_wdata = '0;
        wait_ready(ok);
        if (!ok) fail_now("b2b_accept1");
        @(posedge clk); #1;
        req_size = 2'd0; req_addr = 10'h013;
        wait_ready(ok);
        if (!ok) fail_now("b2b_accept2");
        @(posedge clk); #1;
        drop_req();
        check("b2b_accept_cycle", 64'(acc_cyc), 64'(hs_cyc + 1));
        wait_resp(ok);
        if (!ok) fail_now("b2b_resp2");
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
